// File: rtl/bcd_para_bin_entrada_pkg.sv
// Shared constants for the BCD-to-binary input converter: FSM state encoding,
// digit width and the signed 16-bit range limits used for overflow/saturation.
package bcd_para_bin_entrada_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SINAL = 2'd2,
        ST_FIM   = 2'd3
    } estado_t;

    localparam int BCD_W       = 4;
    localparam int MAX_POS     = 32767;
    localparam int MAX_NEG_MAG = 32768;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/bcd_para_bin_entrada_mul10_soma.sv
// One step of the Horner evaluation: acc*10 + digit at ACC_W bits, plus a
// flag for a non-decimal digit.
module bcd_para_bin_entrada_mul10_soma
    import bcd_para_bin_entrada_pkg::*;
#(
    parameter int ACC_W = 17
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [BCD_W-1:0] digit,
    output logic [ACC_W-1:0] acc_prox,
    output logic             digit_invalido
);

    always_comb begin
        acc_prox       = (acc << 3) + (acc << 1) + ACC_W'(digit);
        digit_invalido = (digit > 4'd9);
    end

endmodule

// File: rtl/bcd_para_bin_entrada.sv
// Iterative BCD (sign + magnitude) to two's-complement converter, one digit per
// clock, MSD first. Define BCD_PARA_BIN_SATURA_EN to saturate bin on overflow.
module bcd_para_bin_entrada
    import bcd_para_bin_entrada_pkg::*;
#(
    parameter int N_DIGITOS = 5,
    parameter int LARGURA   = 16,
    parameter int ACC_W     = 17
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         sinal,
    input  logic [BCD_W*N_DIGITOS-1:0]   bcd,
    output logic [LARGURA-1:0]           bin,
    output logic                         busy,
    output logic                         done,
    output logic                         erro
);

    localparam int CNT_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

    estado_t                      state_q, state_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [BCD_W*N_DIGITOS-1:0]   bcd_q, bcd_d;
    logic                         sinal_q, sinal_d;
    logic                         inv_q, inv_d;
    logic [LARGURA-1:0]           bin_q, bin_d;
    logic                         erro_q, erro_d;

    logic [BCD_W-1:0]             digito;
    logic [ACC_W-1:0]             acc_prox;
    logic                         digit_inv;
    logic                         ovf;

    always_comb begin
        digito = '0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (cnt_q == CNT_W'(i)) digito = bcd_q[i*BCD_W +: BCD_W];
        end
    end

    bcd_para_bin_entrada_mul10_soma #(.ACC_W(ACC_W)) u_mul10_soma (
        .acc            (acc_q),
        .digit          (digito),
        .acc_prox       (acc_prox),
        .digit_invalido (digit_inv)
    );

    // -32768 is representable, +32768 is not
    always_comb begin
        ovf = sinal_q ? (acc_q > ACC_W'(MAX_NEG_MAG)) : (acc_q > ACC_W'(MAX_POS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            sinal_q <= 1'b0;
            inv_q   <= 1'b0;
            bin_q   <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            sinal_q <= sinal_d;
            inv_q   <= inv_d;
            bin_q   <= bin_d;
            erro_q  <= erro_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CONV;
            ST_CONV:  if (cnt_q == '0) state_d = ST_SINAL;
            ST_SINAL: state_d = ST_FIM;
            ST_FIM:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        sinal_d = sinal_q;
        inv_d   = inv_q;
        bin_d   = bin_q;
        erro_d  = erro_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bcd_d   = bcd;
                    sinal_d = sinal;
                    acc_d   = '0;
                    inv_d   = 1'b0;
                    cnt_d   = CNT_W'(N_DIGITOS - 1);
                end
            end
            ST_CONV: begin
                acc_d = acc_prox;
                inv_d = inv_q | digit_inv;
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            ST_SINAL: begin
                if (!inv_q && !ovf) begin
                    bin_d  = sinal_q ? -acc_q[LARGURA-1:0] : acc_q[LARGURA-1:0];
                    erro_d = 1'b0;
                end else begin
                    erro_d = 1'b1;
`ifdef BCD_PARA_BIN_SATURA_EN
                    if (inv_q)        bin_d = '0;
                    else if (sinal_q) bin_d = LARGURA'(SAT_NEG);
                    else              bin_d = LARGURA'(SAT_POS);
`else
                    bin_d = '0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CONV) || (state_q == ST_SINAL);
        done = (state_q == ST_FIM);
        bin  = bin_q;
        erro = erro_q;
    end

endmodule

// File: tb/tb_bcd_para_bin_entrada.sv
// Scoreboard bench for bcd_para_bin_entrada: driver pushes expected results,
// a negedge monitor pops and checks on every done pulse.
module tb_bcd_para_bin_entrada;

    logic        clk = 1'b0;
    logic        reset, start, sinal;
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        busy, done, erro;

    bcd_para_bin_entrada dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sinal (sinal),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .erro  (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic        erro;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   busy_run = 0;

`ifdef BCD_PARA_BIN_SATURA_EN
    localparam logic [15:0] OVF_POS_BIN = 16'h7FFF;
`else
    localparam logic [15:0] OVF_POS_BIN = 16'h0000;
`endif

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done) begin
            check("done_busy_exclusive", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bin", {16'd0, bin}, {16'd0, e.bin});
                check("erro", {31'd0, erro}, {31'd0, e.erro});
                check("done_cycle", cyc, e.cyc);
                check("busy_cycles", busy_run, 6);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    task automatic issue(input logic [19:0] v, input logic s, input logic [15:0] eb, input logic ee);
        exp_t e;
        @(negedge clk);
        bcd   = v;
        sinal = s;
        start = 1'b1;
        e.bin = eb; e.erro = ee; e.cyc = cyc + 1 + 6;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        bcd   = 20'hFFFFF;
        sinal = ~s;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   n0;
        reset = 1'b1; start = 1'b0; sinal = 1'b0; bcd = '0;
        repeat (3) @(negedge clk);
        check("rst_bin", {16'd0, bin}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_erro", {31'd0, erro}, 32'd0);
        reset = 1'b0;

        issue(20'h12345, 1'b0, 16'h3039, 1'b0); drain();
        issue(20'h00128, 1'b1, 16'hFF80, 1'b0); drain();
        issue(20'h00000, 1'b1, 16'h0000, 1'b0); drain();
        issue(20'h32767, 1'b0, 16'h7FFF, 1'b0); drain();
        issue(20'h32768, 1'b1, 16'h8000, 1'b0); drain();
        issue(20'h32768, 1'b0, OVF_POS_BIN, 1'b1); drain();
        issue(20'h1A000, 1'b0, 16'h0000, 1'b1); drain();
        issue(20'h00007, 1'b0, 16'h0007, 1'b0); drain();

        // start held 10 cycles, input changed after capture
        @(negedge clk);
        bcd = 20'h00042; sinal = 1'b0; start = 1'b1;
        n0 = cyc + 1;
        e.bin = 16'h002A; e.erro = 1'b0; e.cyc = n0 + 6;  exp_q.push_back(e);
        e.bin = OVF_POS_BIN; e.erro = 1'b1; e.cyc = n0 + 14; exp_q.push_back(e);
        @(negedge clk);
        bcd = 20'h99999;
        repeat (9) @(negedge clk);
        start = 1'b0;
        drain();

        // reset mid-conversion: sampled at edge N+3
        @(negedge clk);
        bcd = 20'h00555; sinal = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_bin", {16'd0, bin}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_erro", {31'd0, erro}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        issue(20'h00042, 1'b1, 16'hFFD6, 1'b0); drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
